// File: rtl/hssi_axis_lpbk_responder.sv
`default_nettype none
// =============================================================================
// hssi_axis_lpbk_responder: store-and-forward AXI-Stream loopback, 64-bit path
// Rev 1.0
// =============================================================================
module hssi_axis_lpbk_responder #(
  parameter int DEPTH   = 512,
  parameter int TUSER_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lpbk_en,
  input  logic               tx_tvalid,
  output logic               tx_tready,
  input  logic [63:0]        tx_tdata,
  input  logic [7:0]         tx_tkeep,
  input  logic               tx_tlast,
  input  logic [TUSER_W-1:0] tx_tuser,
  output logic               rx_tvalid,
  input  logic               rx_tready,
  output logic [63:0]        rx_tdata,
  output logic [7:0]         rx_tkeep,
  output logic               rx_tlast,
  output logic [TUSER_W-1:0] rx_tuser,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        byte_cnt,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        err_cnt,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = 64 + 8 + 1 + TUSER_W;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_start_q, pkt_start_d;
  logic [AW:0] commit_cnt_q, commit_cnt_d;
  logic [AW:0] avail_q, avail_d;
  logic        ready_en_q;

  logic               rx_tvalid_q;
  logic [63:0]        rx_tdata_q;
  logic [7:0]         rx_tkeep_q;
  logic               rx_tlast_q;
  logic [TUSER_W-1:0] rx_tuser_q;

  logic [31:0] pkt_cnt_q, byte_cnt_q;
  logic [15:0] drop_cnt_q, err_cnt_q;
  logic        overflow_q;

  logic          full, tx_rdy, tx_hs, rx_hs;
  logic          wr_en, commit, drop_pkt, ovf_evt, frame_err;
  logic          fetch, fetch_last, done;
  logic [BW-1:0] rd_word;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // ready_en_q keeps tx_tready low through the first cycle after reset release
  always_comb begin
    tx_rdy = 1'b0;
    if (ready_en_q) begin
      case (state_q)
        ST_IDLE:  tx_rdy = lpbk_en ? !full : 1'b1;
        ST_STORE: tx_rdy = !full;
        ST_DROP:  tx_rdy = 1'b1;
        default:  tx_rdy = 1'b0;
      endcase
    end
  end

  assign tx_tready = tx_rdy;
  assign tx_hs     = tx_tvalid && tx_rdy;

  always_comb begin
    frame_err = 1'b0;
    if (tx_tkeep == 8'h00)
      frame_err = 1'b1;
    else if (!tx_tlast && (tx_tkeep != 8'hFF))
      frame_err = 1'b1;
    else if (tx_tlast && ((tx_tkeep & (tx_tkeep + 8'd1)) != 8'h00))
      frame_err = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    wr_en       = 1'b0;
    commit      = 1'b0;
    drop_pkt    = 1'b0;
    ovf_evt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_hs) begin
          if (lpbk_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (tx_tlast) begin
              commit      = 1'b1;
              pkt_start_d = wr_ptr_q + PTR_ONE;
            end else begin
              state_d = ST_STORE;
            end
          end else begin
            drop_pkt = 1'b1;
            if (!tx_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_STORE: begin
        if (tx_hs) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (tx_tlast) begin
            commit      = 1'b1;
            pkt_start_d = wr_ptr_q + PTR_ONE;
            state_d     = ST_IDLE;
          end
        end else if (full && (commit_cnt_q == '0)) begin
          // Packet cannot fit even with the buffer drained: abandon it
          wr_ptr_d = pkt_start_q;
          drop_pkt = 1'b1;
          ovf_evt  = 1'b1;
          state_d  = ST_DROP;
        end
      end
      ST_DROP: begin
        if (tx_hs && tx_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // avail_q counts committed packets whose tlast has not yet left the memory
  assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_hs      = rx_tvalid_q && rx_tready;
  assign done       = rx_hs && rx_tlast_q;
  assign fetch      = (avail_q != '0) && (!rx_tvalid_q || rx_tready);
  assign fetch_last = fetch && rd_word[TUSER_W];

  assign rd_ptr_d     = fetch ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign commit_cnt_d = commit_cnt_q + (commit ? PTR_ONE : '0) - (done ? PTR_ONE : '0);
  assign avail_d      = avail_q + (commit ? PTR_ONE : '0) - (fetch_last ? PTR_ONE : '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_start_q  <= '0;
      commit_cnt_q <= '0;
      avail_q      <= '0;
      rx_tvalid_q  <= 1'b0;
      rx_tdata_q   <= '0;
      rx_tkeep_q   <= '0;
      rx_tlast_q   <= 1'b0;
      rx_tuser_q   <= '0;
      pkt_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_start_q  <= pkt_start_d;
      commit_cnt_q <= commit_cnt_d;
      avail_q      <= avail_d;

      if (fetch) begin
        rx_tvalid_q <= 1'b1;
        rx_tdata_q  <= rd_word[BW-1 -: 64];
        rx_tkeep_q  <= rd_word[TUSER_W+8 -: 8];
        rx_tlast_q  <= rd_word[TUSER_W];
        rx_tuser_q  <= rd_word[TUSER_W-1:0];
      end else if (rx_hs) begin
        rx_tvalid_q <= 1'b0;
      end

      if (rx_hs) byte_cnt_q <= byte_cnt_q + 32'(popcnt8(rx_tkeep_q));
      if (done)  pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop_pkt && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (wr_en && frame_err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (ovf_evt) overflow_q <= 1'b1;
    end
  end

  assign rx_tvalid = rx_tvalid_q;
  assign rx_tdata  = rx_tdata_q;
  assign rx_tkeep  = rx_tkeep_q;
  assign rx_tlast  = rx_tlast_q;
  assign rx_tuser  = rx_tuser_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign byte_cnt  = byte_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hssi_axis_lpbk_responder.sv
`default_nettype none
// =============================================================================
// tb_hssi_axis_lpbk_responder: vector table, directed corners, random traffic vs packet model
// Rev 1.0
// =============================================================================
module tb_hssi_axis_lpbk_responder;
  localparam int DEPTH   = 16;
  localparam int TUSER_W = 12;

  typedef struct packed {
    logic [63:0]        d;
    logic [7:0]         k;
    logic               l;
    logic [TUSER_W-1:0] u;
  } beat_t;

  typedef struct {
    int         n;
    logic [7:0] mk;
    logic [7:0] lk;
    logic       lp;
    int         e_err;
    int         e_drop;
    int         e_pkt;
    int         e_byte;
  } vec_t;

  logic               clk, rst_n, lpbk_en;
  logic               tx_tvalid, tx_tready, tx_tlast;
  logic [63:0]        tx_tdata;
  logic [7:0]         tx_tkeep;
  logic [TUSER_W-1:0] tx_tuser;
  logic               rx_tvalid, rx_tready, rx_tlast;
  logic [63:0]        rx_tdata;
  logic [7:0]         rx_tkeep;
  logic [TUSER_W-1:0] rx_tuser;
  logic [31:0]        pkt_cnt, byte_cnt;
  logic [15:0]        drop_cnt, err_cnt;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  beat_t       exp_q[$];
  beat_t       cur_q[$];
  beat_t       prev_beat;
  bit          in_pkt, cur_keep, prev_stall;
  bit          ovf_expected, saw_stall, rx_mode, rx_fixed;
  int          cur_idx;
  int unsigned m_pkt, m_byte, m_drop, m_err;
  int unsigned t_pkt, t_byte, t_drop, t_err;
  vec_t        tbl[9];

  hssi_axis_lpbk_responder #(.DEPTH(DEPTH), .TUSER_W(TUSER_W)) dut (
    .clk(clk), .rst_n(rst_n), .lpbk_en(lpbk_en),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .drop_cnt(drop_cnt),
    .err_cnt(err_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ferr(input logic [7:0] k, input logic l);
    bit contig;
    contig = 1'b0;
    for (int n = 1; n <= 8; n++) if (k == 8'((1 << n) - 1)) contig = 1'b1;
    if (k == 8'h00) return 1'b1;
    if (!l) return (k != 8'hFF);
    return !contig;
  endfunction

  // Packet-level reference: a packet is kept iff lpbk_en was 1 on its first beat
  always @(negedge clk) begin
    beat_t b, e, rb;
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      in_pkt = 1'b0;
      prev_stall = 1'b0;
      m_pkt = 0; m_byte = 0; m_drop = 0; m_err = 0;
    end else begin
      rb = {rx_tdata, rx_tkeep, rx_tlast, rx_tuser};
      if (prev_stall) chk("rx_hold", rb, prev_beat);
      prev_stall = rx_tvalid && !rx_tready;
      prev_beat  = rb;
      if (rx_tvalid && rx_tready) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_beat", rb, e);
          m_byte += $countones(e.k);
          if (e.l) m_pkt++;
        end
      end
      if (tx_tvalid && !tx_tready) saw_stall = 1'b1;
      if (tx_tvalid && tx_tready) begin
        b = {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
        if (!in_pkt) begin
          in_pkt   = 1'b1;
          cur_keep = lpbk_en;
          cur_idx  = 0;
          cur_q.delete();
          if (!lpbk_en) m_drop++;
        end
        if (cur_keep && (!ovf_expected || cur_idx < DEPTH) && ferr(b.k, b.l)) m_err++;
        if (cur_keep) cur_q.push_back(b);
        cur_idx++;
        if (b.l) begin
          in_pkt = 1'b0;
          if (cur_keep) begin
            if (ovf_expected) m_drop++;
            else foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          end
        end
      end
    end
  end

  initial begin
    rx_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rx_tready = rx_mode ? 1'($urandom) : rx_fixed;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] k, input logic l);
    bit hs;
    int t;
    t = 0;
    tx_tvalid = 1'b1;
    tx_tdata  = {$urandom, $urandom};
    tx_tkeep  = k;
    tx_tlast  = l;
    tx_tuser  = TUSER_W'($urandom);
    forever begin
      @(negedge clk);
      hs = tx_tready;
      @(posedge clk);
      #1;
      if (hs) break;
      t++;
      if (t > 500) begin
        chk("tx_ready_timeout", 1, 0);
        break;
      end
    end
    tx_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] mk, input logic [7:0] lk, input int tog_at);
    for (int i = 0; i < n; i++) begin
      if (i == tog_at) lpbk_en = 1'b1;
      send_beat((i == n - 1) ? lk : mk, i == n - 1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rx_tvalid) && t < 3000) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", t >= 3000, 0);
    tick(2);
  endtask

  task automatic chk_tot(input string name);
    chk({name, "_pkt_cnt"},  pkt_cnt,  t_pkt);
    chk({name, "_byte_cnt"}, byte_cnt, t_byte);
    chk({name, "_drop_cnt"}, drop_cnt, t_drop);
    chk({name, "_err_cnt"},  err_cnt,  t_err);
    chk({name, "_model_pkt"},  pkt_cnt,  m_pkt);
    chk({name, "_model_byte"}, byte_cnt, m_byte);
  endtask

  initial begin
    //          n   mid    last   lp  err drop pkt byte
    tbl[0] = '{1, 8'hFF, 8'hFF, 1'b1, 0, 0, 1,  8};
    tbl[1] = '{1, 8'hFF, 8'h00, 1'b1, 1, 0, 1,  0};
    tbl[2] = '{2, 8'hF0, 8'h05, 1'b1, 2, 0, 1,  6};
    tbl[3] = '{3, 8'hFF, 8'h01, 1'b1, 0, 0, 1, 17};
    tbl[4] = '{2, 8'hFF, 8'h80, 1'b1, 1, 0, 1,  9};
    tbl[5] = '{4, 8'h7F, 8'hFF, 1'b1, 3, 0, 1, 29};
    tbl[6] = '{2, 8'hFF, 8'h03, 1'b0, 0, 1, 0,  0};
    tbl[7] = '{1, 8'h00, 8'h00, 1'b0, 0, 1, 0,  0};
    tbl[8] = '{5, 8'hFF, 8'h3F, 1'b1, 0, 0, 1, 38};

    rst_n = 1'b0; lpbk_en = 1'b1;
    tx_tvalid = 1'b0; tx_tdata = '0; tx_tkeep = '0; tx_tlast = 1'b0; tx_tuser = '0;
    rx_mode = 1'b0; rx_fixed = 1'b0; ovf_expected = 1'b0; saw_stall = 1'b0;
    tick(3);
    chk("rst_tx_tready", tx_tready, 0);
    chk("rst_rx_tvalid", rx_tvalid, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_low_release_cycle", tx_tready, 0);
    tick(1);
    chk("rdy_high_after_release", tx_tready, 1);

    // 8-beat packet: latency and counts
    rx_fixed = 1'b1;
    tick(1);
    send_pkt(8, 8'hFF, 8'h0F, -1);
    @(negedge clk);
    chk("lat_cycle1_rx_tvalid", rx_tvalid, 0);
    @(negedge clk);
    chk("lat_cycle2_rx_tvalid", rx_tvalid, 1);
    @(posedge clk);
    #1;
    wait_drain();
    t_pkt = 1; t_byte = 60; t_drop = 0; t_err = 0;
    chk_tot("t1");

    for (int i = 0; i < 9; i++) begin
      lpbk_en = tbl[i].lp;
      send_pkt(tbl[i].n, tbl[i].mk, tbl[i].lk, -1);
      lpbk_en = 1'b1;
      wait_drain();
      t_pkt  += tbl[i].e_pkt;
      t_byte += tbl[i].e_byte;
      t_drop += tbl[i].e_drop;
      t_err  += tbl[i].e_err;
      chk_tot($sformatf("vec%0d", i));
    end

    // 100 back-to-back single-beat packets, random RX backpressure
    saw_stall = 1'b0;
    rx_mode = 1'b1;
    for (int i = 0; i < 100; i++) send_beat(8'hFF, 1'b1);
    rx_mode = 1'b0; rx_fixed = 1'b1;
    wait_drain();
    t_pkt += 100; t_byte += 800;
    chk_tot("t2");
    chk("t2_tx_stall_seen", saw_stall, 1);

    // overflow: 20-beat packet into 16-beat buffer with RX stalled
    rx_fixed = 1'b0;
    tick(2);
    ovf_expected = 1'b1;
    send_pkt(20, 8'hFF, 8'hFF, -1);
    tick(2);
    chk("t3_overflow", overflow, 1);
    chk("t3_rx_tvalid", rx_tvalid, 0);
    t_drop += 1;
    chk_tot("t3a");
    ovf_expected = 1'b0;
    rx_fixed = 1'b1;
    send_pkt(4, 8'hFF, 8'hFF, -1);
    wait_drain();
    t_pkt += 1; t_byte += 32;
    chk_tot("t3b");
    chk("t3_overflow_sticky", overflow, 1);

    // lpbk_en=0 for three packets, raised mid-fourth
    lpbk_en = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(2, 8'hFF, 8'hFF, -1);
    send_pkt(3, 8'hFF, 8'hFF, 1);
    send_pkt(2, 8'hFF, 8'hFF, -1);
    wait_drain();
    t_drop += 4; t_pkt += 1; t_byte += 16;
    chk_tot("t4");

    // randomized traffic against the packet model
    rx_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] mk, lk;
      lpbk_en = ($urandom_range(0, 3) != 0);
      mk = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      lk = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'((1 << $urandom_range(1, 8)) - 1);
      send_pkt($urandom_range(1, DEPTH), mk, lk, -1);
      tick($urandom_range(0, 2));
    end
    lpbk_en = 1'b1;
    rx_mode = 1'b0; rx_fixed = 1'b1;
    wait_drain();
    chk("rnd_pkt_cnt",  pkt_cnt,  m_pkt);
    chk("rnd_byte_cnt", byte_cnt, m_byte);
    chk("rnd_drop_cnt", drop_cnt, m_drop);
    chk("rnd_err_cnt",  err_cnt,  m_err);

    // reset with packets buffered and one partly replayed
    rx_fixed = 1'b0;
    tick(2);
    send_pkt(4, 8'hFF, 8'hFF, -1);
    send_pkt(2, 8'hFF, 8'hFF, -1);
    send_pkt(2, 8'hFF, 8'hFF, -1);
    tick(2);
    rx_fixed = 1'b1;
    tick(2);
    rx_fixed = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t7_rx_tvalid", rx_tvalid, 0);
    chk("t7_rx_tlast", rx_tlast, 0);
    chk("t7_rx_tdata", rx_tdata, 0);
    chk("t7_tx_tready", tx_tready, 0);
    chk("t7_overflow", overflow, 0);
    t_pkt = 0; t_byte = 0; t_drop = 0; t_err = 0;
    chk_tot("t7a");
    tick(1);
    chk("t7_tx_tready_back", tx_tready, 1);
    chk("t7_rx_idle", rx_tvalid, 0);
    rx_fixed = 1'b1;
    send_pkt(3, 8'hFF, 8'h07, -1);
    wait_drain();
    t_pkt = 1; t_byte = 19;
    chk_tot("t7b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hssi_axis_lpbk_responder.md
Name: hssi_axis_lpbk_responder

Overview:
Synthesizable store-and-forward loopback responder for one HSSI AXI-Stream channel, 64-bit datapath. It sinks the AFU TX stream (hssi_ss_st_tx) with real backpressure, buffers complete packets, checks framing, and replays each packet unchanged on the RX stream (hssi_ss_st_rx) toward the AFU. One instance per HSSI port, placed between the HE-HSSI AFU and the HSSI-SS boundary for traffic-generator loopback tests without the MAC.

Parameters:
DEPTH, 512, buffer depth in 64-bit beats; power of 2, minimum 16.
TUSER_W, 12, tuser width on both streams.

Ports:
clk  in  1  stream clock
rst_n  in  1  synchronous active-low reset
lpbk_en  in  1  1 = loop packets back; 0 = sink and discard TX traffic
tx_tvalid  in  1  AFU TX beat valid
tx_tready  out  1  responder ready for TX beat
tx_tdata  in  64  TX data
tx_tkeep  in  8  TX byte enables
tx_tlast  in  1  TX end of packet
tx_tuser  in  TUSER_W  TX sideband
rx_tvalid  out  1  RX beat valid toward AFU
rx_tready  in  1  AFU RX ready
rx_tdata  out  64  RX data
rx_tkeep  out  8  RX byte enables
rx_tlast  out  1  RX end of packet
rx_tuser  out  TUSER_W  RX sideband
pkt_cnt  out  32  packets fully replayed on RX (wraps)
byte_cnt  out  32  bytes replayed, popcount of rx_tkeep per accepted beat (wraps)
drop_cnt  out  16  packets dropped (overflow or lpbk_en=0), saturates at 0xFFFF
err_cnt  out  16  framing errors, saturates at 0xFFFF
overflow  out  1  sticky; set on any overflow drop, cleared only by reset

Behaviour:
- Reset (rst_n=0 at clk edge): buffer emptied, pointers and committed-packet count = 0; tx_tready=0, rx_tvalid=0, rx_tlast=0, rx_tdata/tkeep/tuser=0, all counters=0, overflow=0. Any packet in flight is discarded. tx_tready first rises the cycle after rst_n returns high.
- Beats stored as {tdata, tkeep, tlast, tuser}; RX reproduces them bit-exact, in order.
- Ingress states: IDLE (between packets), STORE, DROP.
  - IDLE: on the first beat handshake, sample lpbk_en. 1 -> STORE and write the beat; 0 -> DROP.
  - STORE: tx_tready = buffer not full. tlast handshake commits the packet (count+1 on the next edge) -> IDLE.
  - Overflow: in STORE, buffer full and committed count = 0. Rewind the write pointer to the start of the current packet, set overflow, increment drop_cnt, enter DROP.
  - DROP: tx_tready=1, beats discarded; tlast handshake -> IDLE. Entering DROP from IDLE because lpbk_en=0 also increments drop_cnt.
  - A single-beat packet (tlast on the first beat) commits or drops immediately.
- lpbk_en changes take effect only at packet boundaries. Egress is independent of lpbk_en and drains committed packets.
- Egress: rx_tvalid only while committed count > 0 or a committed packet is partway out. Outputs are registered and hold stable while rx_tvalid=1 and rx_tready=0. Each rx_tlast handshake decrements the committed count and increments pkt_cnt.
- Latency: with egress idle, the first beat appears on rx_tvalid exactly 2 cycles after the TX tlast handshake. Full throughput of 1 beat/cycle on both sides when neither stalls.
- Simultaneous commit and egress tlast on the same edge: committed count unchanged; no lost update.
- Framing errors, checked at ingress on STORE beats: err_cnt+1 per offending beat; the packet is still forwarded unchanged.
  - tkeep=0.
  - Non-last beat with tkeep≠0xFF.
  - Last beat with non-contiguous tkeep (not of form 2^n−1, n=1..8).
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare. pkt_cnt/byte_cnt wrap modulo 2^32.

Test Plan:
- 1 packet of 8 beats, tkeep last=0x0F, rx_tready=1 → identical 8 beats on RX; first rx_tvalid 2 cycles after tx tlast; pkt_cnt=1, byte_cnt=60.
- 100 back-to-back 1-beat packets, rx_tready random 50%, with DEPTH=16 → all replayed in order, no gaps with both ready, pkt_cnt=100, tx_tready drops while full.
- DEPTH=16, one 20-beat packet, rx_tready=0 → after 16 beats overflow=1, drop_cnt=1, remaining 4 beats accepted and discarded, rx_tvalid stays 0; a following 4-beat packet loops back correctly.
- lpbk_en=0 for 3 packets, toggled to 1 mid-fourth-packet → drop_cnt=4, fifth packet replayed, pkt_cnt=1.
- Mid-packet tkeep=0xF0, last tkeep=0x05 → err_cnt=2, packet still replayed bit-exact.
- rst_n asserted for 1 cycle while 2 packets are buffered and one is half-out on RX → next cycle rx_tvalid=0 and all counters 0; a fresh packet afterwards replays normally.
